// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer (main register = head, skid register = second entry).
//
// Handshake: an item moves upstream->stage when in_valid & in_ready (acc), and
// stage->downstream when out_valid & out_ready (fire). in_valid/in_data must
// be held by upstream until accepted; out_valid/out_data are held by the stage
// until consumed. in_ready is a register, so there is no combinational path
// from out_ready to in_ready.
//
// Optional build macro PIPE_STAGE_PERF_EN adds the saturating stall_cnt and
// full_cnt performance counters (and their ports). Without it, the counter
// ports and logic are absent and the handshake is identical.
//
// The FSM state is visible on the occupancy port (EMPTY=0, ONE=1, TWO=2).

module pipe_stage_skid #(
  parameter int                 WIDTH  = 32,
  parameter logic [WIDTH-1:0]   BUBBLE = '0,
  parameter int                 CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] full_cnt
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;

  logic acc;
  logic fire;

  assign acc  = in_valid & in_ready_q;
  assign fire = out_valid_q & out_ready;

  // Next-state and next-payload selection; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // A same-cycle acc is squashed; a same-cycle fire was already consumed.
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && fire) begin
            state_d = ONE;
            main_d  = in_data;
          end else if (acc) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        TWO: begin
          // in_ready is low here, so acc cannot occur.
          if (fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end

    // Handshake outputs are registered copies of the next state's decode.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // Stage registers; asynchronous reset discards every held entry at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] full_cnt_q,  full_cnt_d;

  // Saturating event counters; flush deliberately leaves them untouched.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    full_cnt_d  = full_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (in_valid && !in_ready_q && (full_cnt_q != CNT_MAX)) begin
      full_cnt_d = full_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      full_cnt_q  <= full_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign full_cnt  = full_cnt_q;
`endif

  // Structural invariants of the stage.
  a_bubble_when_idle : assert property (@(posedge CLK) disable iff (!nRST)
    !out_valid_q |-> (main_q == BUBBLE));
  a_state_legal : assert property (@(posedge CLK) disable iff (!nRST)
    state_q != 2'd3);
  a_ready_matches_state : assert property (@(posedge CLK) disable iff (!nRST)
    in_ready_q == (state_q != TWO));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus a randomized run
// checked against a queue-based model of the stage (at most two entries,
// first-in first-out, flush empties it).

module tb_pipe_stage_skid;

  localparam int W        = 32;
  localparam int TB_CNT_W = 3;
  localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;
  localparam logic [W-1:0] B_BUBBLE = 32'hDEAD_0000;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic nRST;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- DUT (BUBBLE = 0, small counters) ----------------
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [TB_CNT_W-1:0] stall_cnt;
  logic [TB_CNT_W-1:0] full_cnt;

  pipe_stage_skid #(.WIDTH(W), .BUBBLE(32'h0), .CNT_W(TB_CNT_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .full_cnt  (full_cnt)
`endif
  );

  // ---------------- second DUT with a non-zero BUBBLE ----------------
  logic         b_flush;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [W-1:0] b_in_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_occupancy;
  logic [W-1:0] b_stall_cnt;
  logic [W-1:0] b_full_cnt;

  pipe_stage_skid #(.WIDTH(W), .BUBBLE(B_BUBBLE), .CNT_W(W)) dut_b (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (b_stall_cnt),
    .full_cnt  (b_full_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  int           m_stall;
  int           m_full;
  int           checks;
  int           failures;

  // Model reset: nothing held, counters cleared.
  task automatic model_reset();
    exp_q.delete();
    m_stall = 0;
    m_full  = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs, advance past the rising edge, update the model.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d,
                             input logic rdy, input logic fl);
    bit can_take;
    bit take;
    bit give;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    can_take  = (exp_q.size() < 2);
    take      = v && can_take;
    give      = (exp_q.size() > 0) && rdy;
    if ((exp_q.size() > 0) && !rdy && (m_stall < CNT_SAT)) m_stall++;
    if (v && !can_take && (m_full < CNT_SAT)) m_full++;
    @(posedge CLK);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (give) void'(exp_q.pop_front());
      if (take) exp_q.push_back(d);
    end
  endtask

  // Synchronised reset pulse, released mid-cycle.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    nRST      = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    // Fill to TWO, then drop reset between edges.
    drive_cycle(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h1111_0002, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL reset_fill_occ got=%0d exp=2", occupancy); end
    in_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL async_rst_out_data got=%h exp=0", out_data); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL async_rst_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_in_ready got=%0b exp=1", in_ready); end
`ifdef PIPE_STAGE_PERF_EN
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL async_rst_stall got=%0d exp=0", stall_cnt); end
`endif
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [3];
    vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, vals[i], 1'b1, 1'b0);
      checks++; if (out_data !== vals[i]) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, vals[i]); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 32'hB1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hB2, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== 32'hB1) begin failures++; $display("FAIL bp_head got=%h exp=b1", out_data); end
    // B1 is consumed on this edge; B2 moves up from skid.
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (out_data !== 32'hB2) begin failures++; $display("FAIL bp_second got=%h exp=b2", out_data); end
    checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL bp_mid_occ got=%0d exp=1", occupancy); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL bp_end_occ got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL bp_end_data got=%h exp=0", out_data); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 32'hC1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hC2, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hC3, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", out_data); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || out_data === 32'hC3) begin failures++; $display("FAIL flush_ghost[%0d] valid=%0b data=%h exp valid=0", i, out_valid, out_data); end
    end
    // Flush together with a fire: the head is consumed, nothing remains.
    drive_cycle(1'b1, 32'hC4, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_fire_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_bubble();
    logic [W-1:0] d;
    d = $urandom();
    checks++; if (b_out_data !== B_BUBBLE) begin failures++; $display("FAIL bubble_idle got=%h exp=%h", b_out_data, B_BUBBLE); end
    b_in_valid  = 1'b1;
    b_in_data   = d;
    b_out_ready = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (b_out_data !== d || b_out_valid !== 1'b1) begin failures++; $display("FAIL bubble_load got=%h/%0b exp=%h/1", b_out_data, b_out_valid, d); end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL bubble_drain_valid got=%0b exp=0", b_out_valid); end
    checks++; if (b_out_data !== B_BUBBLE) begin failures++; $display("FAIL bubble_drain_data got=%h exp=%h", b_out_data, B_BUBBLE); end
    checks++; if (b_occupancy !== 2'd0) begin failures++; $display("FAIL bubble_drain_occ got=%0d exp=0", b_occupancy); end
    b_out_ready = 1'b0;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    do_reset();
    drive_cycle(1'b1, 32'hE1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL perf_stall_sat got=%0d exp=7", stall_cnt); end
    drive_cycle(1'b1, 32'hE2, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hE3, 1'b0, 1'b0);
    checks++; if (full_cnt !== 3'd1) begin failures++; $display("FAIL perf_full got=%0d exp=1", full_cnt); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL perf_stall_flush got=%0d exp=7", stall_cnt); end
    checks++; if (full_cnt !== 3'd1) begin failures++; $display("FAIL perf_full_flush got=%0d exp=1", full_cnt); end
    do_reset();
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL perf_stall_rst got=%0d exp=0", stall_cnt); end
    checks++; if (full_cnt !== 3'd0) begin failures++; $display("FAIL perf_full_rst got=%0d exp=0", full_cnt); end
  endtask
`endif

  task automatic test_random();
    logic         v;
    logic         rdy;
    logic         fl;
    logic [W-1:0] d;
    logic [W-1:0] exp_data;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      exp_data = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
      checks++; if (out_valid !== (exp_q.size() > 0)) begin failures++; $display("FAIL rand_valid[%0d] got=%0b exp=%0b", i, out_valid, exp_q.size() > 0); end
      checks++; if (out_data !== exp_data) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, out_data, exp_data); end
      checks++; if (occupancy !== 2'(exp_q.size())) begin failures++; $display("FAIL rand_occ[%0d] got=%0d exp=%0d", i, occupancy, exp_q.size()); end
      checks++; if (in_ready !== (exp_q.size() < 2)) begin failures++; $display("FAIL rand_in_ready[%0d] got=%0b exp=%0b", i, in_ready, exp_q.size() < 2); end
`ifdef PIPE_STAGE_PERF_EN
      checks++; if (stall_cnt !== TB_CNT_W'(m_stall)) begin failures++; $display("FAIL rand_stall[%0d] got=%0d exp=%0d", i, stall_cnt, m_stall); end
      checks++; if (full_cnt !== TB_CNT_W'(m_full)) begin failures++; $display("FAIL rand_full[%0d] got=%0d exp=%0d", i, full_cnt, m_full); end
`endif
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      d   = $urandom();
      drive_cycle(v, d, rdy, fl);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    nRST        = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b0;
    model_reset();

    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
